// File: rtl/runway_lamp_seq_pkg.sv
// runway_pkg: types shared by the runway approach-lamp sequencer.
//   mode_t  - decoded two-bit wind-mode input
//   state_t - sequencer FSM states
package runway_pkg;

  typedef enum logic [1:0] {
    CALM = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10,
    HAZ  = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    CALM_A,
    CALM_B,
    CHASE_UP,
    CHASE_DN,
    HAZ_ON,
    HAZ_OFF
  } state_t;

endpackage

// File: rtl/runway_lamp_seq_if.sv
// runway_lamp_seq_if: switch-side and lamp-side signals of the sequencer.
//   mode  - wind mode (00 calm, 01 chase-up, 10 chase-down, 11 hazard)
//   hold  - freeze display and divider
//   lamps - lamp drive, bit i = lamp i
//   step  - pulse marking the cycle whose closing edge advances the pattern
// master: board/switch side; slave: the sequencer.
interface runway_lamp_seq_if #(
  parameter int N_LAMPS = 3
) ();
  logic [1:0]         mode;
  logic               hold;
  logic [N_LAMPS-1:0] lamps;
  logic               step;

  modport master (output mode, output hold, input lamps, input step);
  modport slave  (input mode, input hold, output lamps, output step);
endinterface

// File: rtl/runway_lamp_seq_tick_div.sv
// tick_div: step-rate divider for the lamp sequencer.
//   clk, reset (sync, active-high), hold (freezes the count)
//   step - high when count is at its last value and hold is low
// The count wraps to 0 only through a step, so a hold landing on the last
// count leaves it parked there and the step fires as soon as hold drops.
module tick_div #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic step
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign step = !reset && !hold && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset)      count <= '0;
    else if (step)  count <= '0;
    else if (!hold) count <= count + 1'b1;
  end
endmodule

// File: rtl/runway_lamp_seq.sv
// runway_lamp_seq: N-lamp approach-bar sequencer.
//   clk, reset (sync, active-high)
//   bus (slave) - mode/hold in, lamps/step out
// Calm alternation, one-hot chase in either direction and hazard flash.
// Mode is only looked at on step cycles; the lamp register is loaded from
// the decode of the next state so the outputs come straight from flops.
//
// state    | meaning
// CALM_A   | even-index lamps lit
// CALM_B   | odd-index lamps lit
// CHASE_UP | one lamp at pos, moving toward MSB
// CHASE_DN | one lamp at pos, moving toward LSB
// HAZ_ON   | all lamps lit
// HAZ_OFF  | all lamps dark
module runway_lamp_seq
  import runway_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 1
) (
  input logic              clk,
  input logic              reset,
  runway_lamp_seq_if.slave bus
);
  localparam int PW = $clog2(N_LAMPS);
  localparam logic [PW-1:0] POS_LAST = PW'(N_LAMPS - 1);

  function automatic logic [N_LAMPS-1:0] even_mask();
    logic [N_LAMPS-1:0] m;
    for (int i = 0; i < N_LAMPS; i++) m[i] = ((i % 2) == 0);
    return m;
  endfunction

  localparam logic [N_LAMPS-1:0] EVEN = even_mask();

  state_t             state, state_nxt;
  logic [PW-1:0]      pos, pos_nxt;
  logic [N_LAMPS-1:0] lamps_q, lamps_nxt;
  logic               step;
  mode_t              mode_s;
  logic               in_chase;

  assign mode_s   = mode_t'(bus.mode);
  assign in_chase = (state == CHASE_UP) || (state == CHASE_DN);

  tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .hold (bus.hold),
    .step (step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CALM_A;
      pos     <= '0;
      lamps_q <= EVEN;
    end else begin
      state   <= state_nxt;
      pos     <= pos_nxt;
      lamps_q <= lamps_nxt;
    end
  end

  // Direction reversal keeps the current position so the lit lamp does not
  // jump; entering a chase from calm/hazard starts at the end it moves away from.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    if (step) begin
      unique case (mode_s)
        CALM: begin
          state_nxt = (state == CALM_A) ? CALM_B : CALM_A;
          pos_nxt   = '0;
        end
        UP: begin
          state_nxt = CHASE_UP;
          if (in_chase) pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
          else          pos_nxt = '0;
        end
        DN: begin
          state_nxt = CHASE_DN;
          if (in_chase) pos_nxt = (pos == '0) ? POS_LAST : pos - 1'b1;
          else          pos_nxt = POS_LAST;
        end
        HAZ: begin
          state_nxt = (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
          pos_nxt   = '0;
        end
        default: begin
          state_nxt = CALM_A;
          pos_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    lamps_nxt = EVEN;
    case (state_nxt)
      CALM_A:   lamps_nxt = EVEN;
      CALM_B:   lamps_nxt = ~EVEN;
      CHASE_UP,
      CHASE_DN: lamps_nxt = N_LAMPS'(1) << pos_nxt;
      HAZ_ON:   lamps_nxt = '1;
      HAZ_OFF:  lamps_nxt = '0;
      default:  lamps_nxt = EVEN;
    endcase
  end

  assign bus.lamps = lamps_q;
  assign bus.step  = step;
endmodule

// File: tb/tb_runway_lamp_seq.sv
// tb_runway_lamp_seq: directed bench for runway_lamp_seq.
// Three instances: A (N=8, TICK_DIV=1) driven from a vector table,
// B (N=3, TICK_DIV=4) and C (N=4, TICK_DIV=3) driven by short sequences.
module tb_runway_lamp_seq;

  typedef struct packed {
    logic       rst;
    logic       hold;
    logic [1:0] mode;
    logic [7:0] lamps;
    logic       step;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  runway_lamp_seq_if #(.N_LAMPS(8)) if_a ();
  runway_lamp_seq_if #(.N_LAMPS(3)) if_b ();
  runway_lamp_seq_if #(.N_LAMPS(4)) if_c ();

  runway_lamp_seq #(.N_LAMPS(8), .TICK_DIV(1)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  runway_lamp_seq #(.N_LAMPS(3), .TICK_DIV(4)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b));
  runway_lamp_seq #(.N_LAMPS(4), .TICK_DIV(3)) dut_c (.clk(clk), .reset(rst_c), .bus(if_c));

  function automatic vec_t mk(logic r, logic h, logic [1:0] m, logic [7:0] l, logic s);
    vec_t v;
    v.rst = r; v.hold = h; v.mode = m; v.lamps = l; v.step = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [2:0] exp_b;
    logic [3:0] exp_c;
    logic       es;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.mode = 2'b00; if_a.hold = 1'b0;
    if_b.mode = 2'b10; if_b.hold = 1'b0;
    if_c.mode = 2'b00; if_c.hold = 1'b0;

    // rst hold mode lamps step
    vecs.push_back(mk(1, 0, 2'd0, 8'h55, 0));
    vecs.push_back(mk(0, 0, 2'd0, 8'h55, 1));
    vecs.push_back(mk(0, 0, 2'd0, 8'hAA, 1));
    vecs.push_back(mk(0, 0, 2'd0, 8'h55, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'hAA, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h01, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h02, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h04, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h08, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h10, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h20, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h40, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h80, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h01, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h02, 1));
    vecs.push_back(mk(0, 0, 2'd2, 8'h04, 1));
    vecs.push_back(mk(0, 0, 2'd2, 8'h02, 1));
    vecs.push_back(mk(0, 0, 2'd2, 8'h01, 1));
    vecs.push_back(mk(0, 0, 2'd3, 8'h80, 1));
    vecs.push_back(mk(0, 0, 2'd3, 8'hFF, 1));
    vecs.push_back(mk(0, 0, 2'd3, 8'h00, 1));
    vecs.push_back(mk(0, 0, 2'd0, 8'hFF, 1));
    vecs.push_back(mk(0, 0, 2'd2, 8'h55, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h80, 1));
    vecs.push_back(mk(0, 1, 2'd1, 8'h01, 0));
    vecs.push_back(mk(0, 1, 2'd2, 8'h01, 0));
    vecs.push_back(mk(0, 0, 2'd1, 8'h01, 1));
    vecs.push_back(mk(0, 1, 2'd1, 8'h02, 0));
    vecs.push_back(mk(1, 1, 2'd1, 8'h02, 0));
    vecs.push_back(mk(1, 1, 2'd1, 8'h55, 0));
    vecs.push_back(mk(0, 0, 2'd1, 8'h55, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h01, 1));
    vecs.push_back(mk(0, 0, 2'd1, 8'h02, 1));

    repeat (2) @(posedge clk);

    // Instance A: table-driven, one row per clock cycle.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst_a = vecs[i].rst; if_a.hold = vecs[i].hold; if_a.mode = vecs[i].mode;
      #1;
      check($sformatf("A[%0d] lamps", i), 32'(if_a.lamps), 32'(vecs[i].lamps));
      check($sformatf("A[%0d] step", i), 32'(if_a.step), 32'(vecs[i].step));
    end

    // Instance B: divider by 4, chase-down, mode toggled between steps.
    @(posedge clk); #2;
    check("B reset lamps", 32'(if_b.lamps), 32'(3'b101));
    check("B reset step", 32'(if_b.step), 32'(1'b0));
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      rst_b = 1'b0;
      if_b.mode = ((c % 4) == 0) ? 2'b10 : (((c % 2) == 1) ? 2'b01 : 2'b11);
      #1;
      if (c <= 4)       exp_b = 3'b101;
      else if (c <= 8)  exp_b = 3'b100;
      else if (c <= 12) exp_b = 3'b010;
      else if (c <= 16) exp_b = 3'b001;
      else              exp_b = 3'b100;
      es = ((c % 4) == 0);
      check($sformatf("B c%0d lamps", c), 32'(if_b.lamps), 32'(exp_b));
      check($sformatf("B c%0d step", c), 32'(if_b.step), 32'(es));
    end

    // Instance C: divider by 3, hold parked on the last count.
    @(posedge clk); #2;
    check("C reset lamps", 32'(if_c.lamps), 32'(4'b0101));
    check("C reset step", 32'(if_c.step), 32'(1'b0));
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      rst_c = 1'b0;
      if_c.hold = (c >= 3) && (c <= 7);
      if_c.mode = (c == 5) ? 2'b11 : 2'b00;
      #1;
      exp_c = (c <= 8) ? 4'b0101 : 4'b1010;
      es = (c == 8) || (c == 11);
      check($sformatf("C c%0d lamps", c), 32'(if_c.lamps), 32'(exp_c));
      check($sformatf("C c%0d step", c), 32'(if_c.step), 32'(es));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
